// File: rtl/debounce_array_if.sv
// rtl/debounce_array_if.sv - button/debounce signal bundle for debounce_array
//
// Purpose: groups the raw button inputs and the per-channel debounced
// outputs of debounce_array into one bundle.
// Signals (all NCH wide except tick_o):
//   button_i   raw asynchronous push-button levels (driven by the source)
//   level_o    debounced, registered level per channel
//   press_o    one-clk pulse on each accepted 0->1 change
//   release_o  one-clk pulse on each accepted 1->0 change
//   toggle_o   flips on every press
//   tick_o     registered sample strobe (1 bit)
// Modports: master = button source / observer, slave = debouncer.

interface debounce_array_if #(
  parameter int unsigned NCH = 4
) ();

  logic [NCH-1:0] button_i;
  logic [NCH-1:0] level_o;
  logic [NCH-1:0] press_o;
  logic [NCH-1:0] release_o;
  logic [NCH-1:0] toggle_o;
  logic           tick_o;

  modport master (
    output button_i,
    input  level_o,
    input  press_o,
    input  release_o,
    input  toggle_o,
    input  tick_o
  );

  modport slave (
    input  button_i,
    output level_o,
    output press_o,
    output release_o,
    output toggle_o,
    output tick_o
  );

endinterface

// File: rtl/debounce_array.sv
// rtl/debounce_array.sv - multi-channel push-button debouncer with edge pulses
//
// Purpose: synchronises NCH raw button inputs, samples them on a shared
// prescaled tick, and accepts a new level on a channel only after STABLE
// consecutive ticks that all disagree with the current debounced level.
// Ports:
//   clk   sole clock, everything updates on its rising edge
//   rst   synchronous, active-high reset
//   bus   debounce_array_if.slave: button_i in; level_o, press_o,
//         release_o, toggle_o, tick_o out (all registered)
// Parameters:
//   NCH       channels, 1..32
//   TICK_DIV  clk cycles per sample tick, >= 1
//   STABLE    consecutive disagreeing ticks needed, 2..255
//   INIT      reset level of synchronisers and debounced levels

module debounce_array #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned STABLE   = 8,
  parameter logic        INIT     = 1'b0
) (
  input logic           clk,
  input logic           rst,
  debounce_array_if.slave bus
);

  // A one-state prescaler still needs a 1-bit register to stay legal.
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

  // Two-flop synchroniser; only sync2_q is observed downstream.
  logic [NCH-1:0] sync1_q;
  logic [NCH-1:0] sync2_q;

  logic [PW-1:0]  pre_q;
  logic [PW-1:0]  pre_d;
  logic           tick_q;
  logic           tick_d;

  logic [NCH-1:0] level_q;
  logic [NCH-1:0] level_d;
  logic [NCH-1:0] press_q;
  logic [NCH-1:0] press_d;
  logic [NCH-1:0] release_q;
  logic [NCH-1:0] release_d;
  logic [NCH-1:0] toggle_q;
  logic [NCH-1:0] toggle_d;

  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];

  // Prescaler. tick is registered from the next count so that tick_q is
  // high exactly in the cycles where pre_q sits at its last value; the
  // debounce logic below is gated by tick_q alone.
  always_comb begin
    pre_d  = '0;
    tick_d = 1'b0;
    if (pre_q != PRE_LAST) begin
      pre_d = pre_q + 1'b1;
    end
    tick_d = (pre_d == PRE_LAST);
  end

  // Per-channel qualification. Any tick that agrees with the current
  // level clears the counter, so a single glitch restarts the count. The
  // STABLE-th consecutive disagreeing tick commits the new level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < int'(NCH); i++) begin
      if (tick_q) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // Pulses are registered edges of the committed level, so they line
    // up with the first cycle level_o shows the new value.
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    toggle_d  = toggle_q ^ press_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= {NCH{INIT}};
      sync2_q   <= {NCH{INIT}};
      pre_q     <= '0;
      tick_q    <= 1'b0;
      level_q   <= {NCH{INIT}};
      press_q   <= '0;
      release_q <= '0;
      toggle_q  <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus.button_i;
      sync2_q   <= sync1_q;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      for (int i = 0; i < int'(NCH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.level_o   = level_q;
  assign bus.press_o   = press_q;
  assign bus.release_o = release_q;
  assign bus.toggle_o  = toggle_q;
  assign bus.tick_o    = tick_q;

endmodule

// File: doc/debounce_array.md
DEBOUNCE_ARRAY -- requirements
Module: debounce_array

Interface
REQ-001 Parameter NCH, default 4: number of independent button channels, 1..32.
REQ-002 Parameter TICK_DIV, default 50000: clk cycles per sample tick, >=1.
REQ-003 Parameter STABLE, default 8: consecutive identical samples needed to accept a new level, 2..255.
REQ-004 Parameter INIT, default 1'b0: reset level of the synchroniser flops and the debounced outputs, applied to every channel.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 button  input  NCH  raw asynchronous push-button levels.
REQ-008 level  output  NCH  debounced, registered level per channel.
REQ-009 press  output  NCH  one-clk pulse on each accepted 0->1 level change.
REQ-010 release  output  NCH  one-clk pulse on each accepted 1->0 level change.
REQ-011 toggle  output  NCH  registered bit that flips on each press.
REQ-012 tick  output  1  registered sample strobe, exposed for verification.

Function
REQ-013 Each button bit SHALL pass through a 2-flop synchroniser clocked every clk; only the second flop (sample) SHALL feed later logic.
REQ-014 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be high exactly in cycles where the count equals TICK_DIV-1; with TICK_DIV=1, tick SHALL be high every cycle.
REQ-015 Each channel SHALL own a counter cnt of width clog2(STABLE), updated only in tick cycles.
REQ-016 In a tick cycle with sample==level[i], cnt[i] SHALL clear to 0 (any glitch restarts qualification).
REQ-017 In a tick cycle with sample!=level[i] and cnt[i]<STABLE-1, cnt[i] SHALL increment by 1.
REQ-018 In a tick cycle with sample!=level[i] and cnt[i]==STABLE-1, level[i] SHALL take sample at that edge and cnt[i] SHALL clear to 0.
REQ-019 press[i] SHALL be high for exactly the one cycle in which level[i] first reads 1 after reading 0; release[i] likewise for a first read of 0; both SHALL be low in all other cycles.
REQ-020 toggle[i] SHALL invert at the same edge where level[i] rises; it SHALL not change on a fall.
REQ-021 Latency: a clean input change SHALL reach level 2 clk synchroniser delay plus STABLE tick cycles after the input change, counting from the first tick that samples the new value.
REQ-022 Channels SHALL be fully independent; simultaneous accepted changes on several channels SHALL pulse press/release on all of them in the same cycle.
REQ-023 Without a tick, level, cnt, toggle SHALL hold and press/release SHALL be 0.

Reset
REQ-024 With rst high at a clk edge: synchroniser flops and level SHALL load INIT, cnt and prescaler SHALL load 0, toggle/press/release/tick SHALL load 0.
REQ-025 rst SHALL take priority over every other event, including a tick in the same cycle; a qualification in progress SHALL be discarded.
REQ-026 Leaving reset SHALL not itself generate press/release; a button held opposite to INIT SHALL be accepted only after a full STABLE-tick qualification.

Verification (NCH=2, TICK_DIV=4, STABLE=3, INIT=0 unless stated)
REQ-027 Reset, then button[0]=1 held -> tick every 4th clk; level[0]=1 at the 3rd tick sampling 1; press[0] one clk; toggle[0]=1; channel 1 all 0.
REQ-028 button[0] bounces 1,1,0 across three ticks, then steady 1 -> no press during the bounce; press[0] only after 3 further consecutive ticks sampling 1.
REQ-029 From level[0]=1, button[0]=0 held -> release[0] pulse at the 3rd tick sampling 0; toggle[0] unchanged; second press then toggles toggle[0] back to 0.
REQ-030 Both buttons rise in the same clk -> press[1:0]=2'b11 in one cycle; level=2'b11.
REQ-031 rst asserted for 1 clk with cnt[0]=2 and button[0]=1 -> level[0]=0 after reset, no pulse; press[0] after 3 fresh ticks.
REQ-032 TICK_DIV=1, STABLE=2 -> tick constantly 1; level follows a steady input change 4 clk later (2 sync + 2 ticks).
